// File: rtl/prio_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prio_rr_arbiter
// Description : N-way request arbiter with a registered one-hot grant and a
//               binary grant index. The selection policy is picked at runtime:
//               fixed priority (lowest index wins) or round-robin starting at
//               a rotating pointer. A grant is held until the owner signals
//               done, drops its request, or holds it for MAX_HOLD cycles. In
//               the last case the grant is force-released and a one-cycle
//               timeout pulse is raised.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               req       - request vector, bit i = requester i
//               done      - owner releases the grant (sampled in GRANT only)
//               rr_mode   - 0 = fixed priority, 1 = round-robin (sampled
//                           when arbitrating in IDLE)
//               gnt       - registered one-hot grant
//               gnt_idx   - binary index of the granted requester
//               gnt_valid - high while a grant is held
//               timeout   - one-cycle pulse on a forced release
// Revision    : 1.0 - initial release
// ============================================================================
module prio_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  input  logic            rr_mode,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  // Hold counter must be able to represent MAX_HOLD itself.
  localparam int              HCW        = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0]  HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0]  HOLD_FIRST = HCW'(1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic [N-1:0]    rot_req;     // req rotated so that bit 0 is requester ptr
  logic [IDXW-1:0] rr_off;      // offset of the first set bit in rot_req
  logic [IDXW-1:0] rr_idx;
  logic [IDXW-1:0] fp_idx;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_onehot;
  logic            any_req;
  logic            owner_gone;
  logic            hold_expired;
  logic [IDXW-1:0] next_ptr;

  // Modulo-N wrap for a sum of two values that are each below N.
  function automatic int wrap_n(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  assign any_req = |req;

  // --------------------------------------------------------------------------
  // Fixed priority: scan from the top down so the lowest set index is the
  // last assignment to stick. All-zero req falls through to the default.
  // --------------------------------------------------------------------------
  always_comb begin
    fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        fp_idx = IDXW'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin: rotate req so the scan always starts at bit 0, find the
  // lowest set bit of the rotated vector, then add ptr back (mod N).
  // --------------------------------------------------------------------------
  always_comb begin
    rot_req = '0;
    for (int k = 0; k < N; k++) begin
      rot_req[k] = req[wrap_n(int'(ptr) + k)];
    end
  end

  always_comb begin
    rr_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        rr_off = IDXW'(k);
      end
    end
  end

  assign rr_idx  = IDXW'(wrap_n(int'(ptr) + int'(rr_off)));
  assign win_idx = rr_mode ? rr_idx : fp_idx;

  // Index-to-one-hot decode of the winner.
  generate
    for (genvar g = 0; g < N; g++) begin : g_win_dec
      assign win_onehot[g] = (win_idx == IDXW'(g));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // GRANT exit conditions. A voluntary release (done or dropped request)
  // takes precedence over the hold limit, so a coincident done suppresses
  // the timeout pulse.
  // --------------------------------------------------------------------------
  assign owner_gone   = done || !req[gnt_idx];
  assign hold_expired = (hold_cnt == HOLD_LIMIT);
  assign next_ptr     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GRANT;
            gnt       <= win_onehot;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= HOLD_FIRST;
          end
        end

        GRANT: begin
          if (owner_gone || hold_expired) begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            // Pointer advances in fixed mode too, so a later switch to
            // round-robin starts from a sensible place.
            ptr       <= next_ptr;
            timeout   <= !owner_gone;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RELEASE: begin
          // gnt_idx keeps its last value through the bubble.
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output invariants.
  // --------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));
  a_valid_matches : assert property (@(posedge clk) disable iff (rst)
    gnt_valid == (|gnt));
  a_idx_matches : assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> gnt[gnt_idx]);

endmodule
`default_nettype wire

// File: tb/tb_prio_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_rr_arbiter
// Description : Directed self-checking bench for prio_rr_arbiter (N=4,
//               MAX_HOLD=8). Covers reset, fixed priority, round-robin wrap,
//               hold timeout, done/drop/limit coincidence and mid-grant reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_rr_arbiter;

  localparam int N        = 4;
  localparam int IDXW     = 2;
  localparam int MAX_HOLD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            done;
  logic            rr_mode;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  int n_cmp = 0;
  int n_err = 0;

  prio_rr_arbiter #(
    .N        (N),
    .IDXW     (IDXW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_gnt,
                             input logic [1:0] exp_idx);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
    check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    logic [1:0] rr_seq [6];
    rr_seq = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};

    // ---------------- reset with all requests pending ----------------
    rst = 1'b1; req = 4'b1111; done = 1'b0; rr_mode = 1'b0;
    tick();
    tick();
    check_idle("reset", 1'b0);
    check("reset.idx", 32'(gnt_idx), 32'd0);

    rst = 1'b0;
    tick();
    check_grant("first_grant", 4'b0001, 2'd0);

    // ---------------- fixed priority, req=1010 ----------------
    req = 4'b1010; done = 1'b1;
    tick();                               // RELEASE, ptr=1
    check_idle("fp_rel0", 1'b0);
    check("fp_rel0.idx_hold", 32'(gnt_idx), 32'd0);
    done = 1'b0;
    tick();                               // IDLE
    check_idle("fp_idle0", 1'b0);
    tick();
    check_grant("fp_g1", 4'b0010, 2'd1);
    done = 1'b1;
    tick();                               // RELEASE, ptr=2
    check_idle("fp_rel1", 1'b0);
    done = 1'b0;
    tick();
    tick();
    check_grant("fp_g2", 4'b0010, 2'd1); // bit3 still loses to bit1

    // ---------------- round-robin with wrap, req=1011 ----------------
    rr_mode = 1'b1; req = 4'b1011; done = 1'b1;
    tick();                               // RELEASE, ptr=2
    tick();                               // IDLE
    for (int i = 0; i < 6; i++) begin
      tick();
      check_grant($sformatf("rr_g%0d", i), 4'(1 << rr_seq[i]), rr_seq[i]);
      tick();
      check_idle($sformatf("rr_rel%0d", i), 1'b0);
      tick();
      check_idle($sformatf("rr_idle%0d", i), 1'b0);
    end
    // ptr=2 after the last grant (idx1)

    // ---------------- hold timeout, req=0100 ----------------
    rr_mode = 1'b0; req = 4'b0100; done = 1'b0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      check($sformatf("to_hold%0d.gnt", i), 32'(gnt), 32'h4);
      check($sformatf("to_hold%0d.to", i), 32'(timeout), 32'd0);
    end
    tick();
    check_idle("to_pulse", 1'b1);
    check("to_pulse.idx_hold", 32'(gnt_idx), 32'd2);
    tick();
    check_idle("to_after", 1'b0);
    tick();
    check_grant("to_regrant", 4'b0100, 2'd2);

    // ---------------- done + drop + hold limit together ----------------
    req = 4'b0000;
    tick();                               // RELEASE, ptr=3
    tick();                               // IDLE, nothing requested
    check_idle("sim_idle", 1'b0);
    req = 4'b0010;
    tick();                               // GRANT idx1, hold=1
    check_grant("sim_g", 4'b0010, 2'd1);
    for (int i = 0; i < MAX_HOLD - 1; i++) tick();  // hold=MAX_HOLD
    check_grant("sim_at_limit", 4'b0010, 2'd1);
    req = 4'b0000; done = 1'b1;
    tick();
    check_idle("sim_rel", 1'b0);
    done = 1'b0; req = 4'b1111; rr_mode = 1'b1;
    tick();                               // requests ignored in RELEASE
    check_idle("sim_ignored", 1'b0);
    tick();
    check_grant("sim_ptr2", 4'b0100, 2'd2);

    // ---------------- reset mid-grant ----------------
    req = 4'b1000;
    tick();                               // RELEASE, ptr=3
    tick();                               // IDLE
    tick();
    check_grant("mid_g3", 4'b1000, 2'd3);
    rst = 1'b1;
    tick();
    check_idle("mid_rst", 1'b0);
    rst = 1'b0; rr_mode = 1'b1; req = 4'b1001;
    tick();
    check_grant("mid_after", 4'b0001, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
